// File: rtl/aes128_if.sv
// Request/response bundle between the crypto register front-end (master) and aes128_core (slave).
// AES_BUSY_EN adds the busy status line.
interface aes128_if;
  logic         start;
  logic [127:0] plaintext;
  logic [127:0] key;
  logic [127:0] ciphertext;
  logic         done;
`ifdef AES_BUSY_EN
  logic         busy;

  modport master (output start, plaintext, key, input ciphertext, done, busy);
  modport slave  (input start, plaintext, key, output ciphertext, done, busy);
`else
  modport master (output start, plaintext, key, input ciphertext, done);
  modport slave  (input start, plaintext, key, output ciphertext, done);
`endif
endinterface

// File: rtl/aes128_core.sv
// Iterative AES-128 encryptor: one round per clock with on-the-fly key expansion.
// Optional feature macro: AES_BUSY_EN adds a busy status output on the interface.
module aes128_core (
  input  logic     clk,
  input  logic     rst,
  aes128_if.slave  bus
);

  typedef enum logic {IDLE, BUSY} fsm_t;

  localparam logic [7:0] SBOX [256] = '{
    8'h63, 8'h7c, 8'h77, 8'h7b, 8'hf2, 8'h6b, 8'h6f, 8'hc5, 8'h30, 8'h01, 8'h67, 8'h2b, 8'hfe, 8'hd7, 8'hab, 8'h76,
    8'hca, 8'h82, 8'hc9, 8'h7d, 8'hfa, 8'h59, 8'h47, 8'hf0, 8'had, 8'hd4, 8'ha2, 8'haf, 8'h9c, 8'ha4, 8'h72, 8'hc0,
    8'hb7, 8'hfd, 8'h93, 8'h26, 8'h36, 8'h3f, 8'hf7, 8'hcc, 8'h34, 8'ha5, 8'he5, 8'hf1, 8'h71, 8'hd8, 8'h31, 8'h15,
    8'h04, 8'hc7, 8'h23, 8'hc3, 8'h18, 8'h96, 8'h05, 8'h9a, 8'h07, 8'h12, 8'h80, 8'he2, 8'heb, 8'h27, 8'hb2, 8'h75,
    8'h09, 8'h83, 8'h2c, 8'h1a, 8'h1b, 8'h6e, 8'h5a, 8'ha0, 8'h52, 8'h3b, 8'hd6, 8'hb3, 8'h29, 8'he3, 8'h2f, 8'h84,
    8'h53, 8'hd1, 8'h00, 8'hed, 8'h20, 8'hfc, 8'hb1, 8'h5b, 8'h6a, 8'hcb, 8'hbe, 8'h39, 8'h4a, 8'h4c, 8'h58, 8'hcf,
    8'hd0, 8'hef, 8'haa, 8'hfb, 8'h43, 8'h4d, 8'h33, 8'h85, 8'h45, 8'hf9, 8'h02, 8'h7f, 8'h50, 8'h3c, 8'h9f, 8'ha8,
    8'h51, 8'ha3, 8'h40, 8'h8f, 8'h92, 8'h9d, 8'h38, 8'hf5, 8'hbc, 8'hb6, 8'hda, 8'h21, 8'h10, 8'hff, 8'hf3, 8'hd2,
    8'hcd, 8'h0c, 8'h13, 8'hec, 8'h5f, 8'h97, 8'h44, 8'h17, 8'hc4, 8'ha7, 8'h7e, 8'h3d, 8'h64, 8'h5d, 8'h19, 8'h73,
    8'h60, 8'h81, 8'h4f, 8'hdc, 8'h22, 8'h2a, 8'h90, 8'h88, 8'h46, 8'hee, 8'hb8, 8'h14, 8'hde, 8'h5e, 8'h0b, 8'hdb,
    8'he0, 8'h32, 8'h3a, 8'h0a, 8'h49, 8'h06, 8'h24, 8'h5c, 8'hc2, 8'hd3, 8'hac, 8'h62, 8'h91, 8'h95, 8'he4, 8'h79,
    8'he7, 8'hc8, 8'h37, 8'h6d, 8'h8d, 8'hd5, 8'h4e, 8'ha9, 8'h6c, 8'h56, 8'hf4, 8'hea, 8'h65, 8'h7a, 8'hae, 8'h08,
    8'hba, 8'h78, 8'h25, 8'h2e, 8'h1c, 8'ha6, 8'hb4, 8'hc6, 8'he8, 8'hdd, 8'h74, 8'h1f, 8'h4b, 8'hbd, 8'h8b, 8'h8a,
    8'h70, 8'h3e, 8'hb5, 8'h66, 8'h48, 8'h03, 8'hf6, 8'h0e, 8'h61, 8'h35, 8'h57, 8'hb9, 8'h86, 8'hc1, 8'h1d, 8'h9e,
    8'he1, 8'hf8, 8'h98, 8'h11, 8'h69, 8'hd9, 8'h8e, 8'h94, 8'h9b, 8'h1e, 8'h87, 8'he9, 8'hce, 8'h55, 8'h28, 8'hdf,
    8'h8c, 8'ha1, 8'h89, 8'h0d, 8'hbf, 8'he6, 8'h42, 8'h68, 8'h41, 8'h99, 8'h2d, 8'h0f, 8'hb0, 8'h54, 8'hbb, 8'h16
  };

  function automatic logic [7:0] sbox(input logic [7:0] x);
    return SBOX[x];
  endfunction

  // Multiply by x in GF(2^8) modulo 0x11b.
  function automatic logic [7:0] xtime(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [7:0] rcon(input logic [3:0] r);
    case (r)
      4'd1:    return 8'h01;
      4'd2:    return 8'h02;
      4'd3:    return 8'h04;
      4'd4:    return 8'h08;
      4'd5:    return 8'h10;
      4'd6:    return 8'h20;
      4'd7:    return 8'h40;
      4'd8:    return 8'h80;
      4'd9:    return 8'h1b;
      4'd10:   return 8'h36;
      default: return 8'h00;
    endcase
  endfunction

  fsm_t         fsm, fsm_next;
  logic [3:0]   round;
  logic [127:0] state, rkey, ct;
  logic         done_q;
  logic         accept, finish;

  logic [7:0]   sb [16];
  logic [7:0]   sr [16];
  logic [7:0]   mc [16];
  logic [127:0] mix_out, state_next, rkey_next;
  logic [31:0]  rot, sub, kn0, kn1, kn2, kn3;

  // Key step: runs in parallel with the data round and feeds its AddRoundKey.
  assign rot       = {rkey[23:0], rkey[31:24]};
  assign sub       = {sbox(rot[31:24]), sbox(rot[23:16]), sbox(rot[15:8]), sbox(rot[7:0])};
  assign kn0       = rkey[127:96] ^ sub ^ {rcon(round), 24'h0};
  assign kn1       = rkey[95:64] ^ kn0;
  assign kn2       = rkey[63:32] ^ kn1;
  assign kn3       = rkey[31:0]  ^ kn2;
  assign rkey_next = {kn0, kn1, kn2, kn3};

  // Byte i of the block is [127-8i -: 8]; byte index = row + 4*column.
  always_comb begin
    for (int i = 0; i < 16; i++) sb[i] = sbox(state[127-8*i -: 8]);
    for (int c = 0; c < 4; c++)
      for (int r = 0; r < 4; r++)
        sr[4*c+r] = sb[4*((c+r)%4)+r];
    for (int c = 0; c < 4; c++) begin
      mc[4*c]   = xtime(sr[4*c]) ^ xtime(sr[4*c+1]) ^ sr[4*c+1] ^ sr[4*c+2] ^ sr[4*c+3];
      mc[4*c+1] = sr[4*c] ^ xtime(sr[4*c+1]) ^ xtime(sr[4*c+2]) ^ sr[4*c+2] ^ sr[4*c+3];
      mc[4*c+2] = sr[4*c] ^ sr[4*c+1] ^ xtime(sr[4*c+2]) ^ xtime(sr[4*c+3]) ^ sr[4*c+3];
      mc[4*c+3] = xtime(sr[4*c]) ^ sr[4*c] ^ sr[4*c+1] ^ sr[4*c+2] ^ xtime(sr[4*c+3]);
    end
    for (int i = 0; i < 16; i++)
      mix_out[127-8*i -: 8] = (round == 4'd10) ? sr[i] : mc[i];
  end

  assign state_next = mix_out ^ rkey_next;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) fsm <= IDLE;
    else      fsm <= fsm_next;
  end

  // NOTE: every output of this block gets a default first so no path leaves it unassigned and infers a latch.
  always_comb begin
    fsm_next = fsm;
    accept   = 1'b0;
    finish   = 1'b0;
    case (fsm)
      IDLE: if (bus.start) begin
        accept   = 1'b1;
        fsm_next = BUSY;
      end
      BUSY: if (round == 4'd10) begin
        finish   = 1'b1;
        fsm_next = IDLE;
      end
      default: fsm_next = IDLE;
    endcase
  end

  // NOTE: the working block and round key are explicitly reset so an aborted operation leaves no key material behind.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state  <= '0;
      rkey   <= '0;
      round  <= '0;
      ct     <= '0;
      done_q <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments so every register samples pre-edge values of the others.
      done_q <= finish;
      if (accept) begin
        state <= bus.plaintext ^ bus.key;
        rkey  <= bus.key;
        round <= 4'd1;
      end else if (fsm == BUSY) begin
        state <= state_next;
        rkey  <= rkey_next;
        round <= finish ? 4'd0 : round + 4'd1;
      end
      if (finish) ct <= state_next;
    end
  end

  assign bus.ciphertext = ct;
  assign bus.done       = done_q;
`ifdef AES_BUSY_EN
  assign bus.busy       = (fsm == BUSY);
`endif

endmodule

// File: tb/tb_aes128_core.sv
// Self-checking bench for aes128_core: FIPS-197 reference model plus directed vectors.
// Define AES_BUSY_EN for both bench and RTL to also check the busy output.
module tb_aes128_core;

  logic clk = 1'b0;
  logic rst = 1'b0;
  int   n_total = 0;
  int   n_bad   = 0;
  int   done_cnt = 0;

  aes128_if bus();

  aes128_core dut (.clk(clk), .rst(rst), .bus(bus));

  always #5 clk = ~clk;

  localparam logic [127:0] C1_PT  = 128'h00112233445566778899aabbccddeeff;
  localparam logic [127:0] C1_KEY = 128'h000102030405060708090a0b0c0d0e0f;
  localparam logic [127:0] C1_CT  = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
  localparam logic [127:0] Z_CT   = 128'h66e94bd4ef8a2c3b884cfa59ca342b2e;
  localparam logic [127:0] E_KEY  = 128'h2b7e151628aed2a6abf7158809cf4f3c;
  localparam logic [127:0] E_PT1  = 128'h6bc1bee22e409f96e93d7e117393172a;
  localparam logic [127:0] E_CT1  = 128'h3ad77bb40d7a3660a89ecaf32466ef97;
  localparam logic [127:0] E_PT2  = 128'hae2d8a571e03ac9c9eb76fac45af8e51;
  localparam logic [127:0] E_CT2  = 128'hf5d3d58503b9699de785895a96fdbaaf;

  task automatic check(input string nm, input logic [127:0] act, input logic [127:0] exp);
    n_total++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h want %h", nm, act, exp);
    end
  endtask

  // ---------------- reference model (FIPS-197, arithmetic S-box) ----------------
  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p = 8'h00;
    for (int i = 0; i < 8; i++) begin
      if (b[0]) p ^= a;
      a = a[7] ? ({a[6:0], 1'b0} ^ 8'h1b) : {a[6:0], 1'b0};
      b = b >> 1;
    end
    return p;
  endfunction

  function automatic logic [7:0] ref_sbox(input logic [7:0] x);
    logic [7:0] inv = 8'h01;
    logic [7:0] s;
    for (int i = 0; i < 254; i++) inv = gmul(inv, x);
    if (x == 8'h00) inv = 8'h00;
    s = inv ^ {inv[6:0], inv[7]} ^ {inv[5:0], inv[7:6]} ^ {inv[4:0], inv[7:5]} ^ {inv[3:0], inv[7:4]} ^ 8'h63;
    return s;
  endfunction

  function automatic logic [31:0] sub_word(input logic [31:0] w);
    return {ref_sbox(w[31:24]), ref_sbox(w[23:16]), ref_sbox(w[15:8]), ref_sbox(w[7:0])};
  endfunction

  function automatic logic [127:0] aes_ref(input logic [127:0] pt, input logic [127:0] k);
    logic [31:0]  w [44];
    logic [31:0]  tmp;
    logic [7:0]   rc = 8'h01;
    logic [7:0]   s [16];
    logic [7:0]   t [16];
    logic [127:0] out;
    for (int i = 0; i < 4; i++) w[i] = k[127-32*i -: 32];
    for (int i = 4; i < 44; i++) begin
      tmp = w[i-1];
      if (i % 4 == 0) begin
        tmp = sub_word({tmp[23:0], tmp[31:24]}) ^ {rc, 24'h0};
        rc  = gmul(rc, 8'h02);
      end
      w[i] = w[i-4] ^ tmp;
    end
    for (int i = 0; i < 16; i++) s[i] = pt[127-8*i -: 8] ^ w[i/4][31-8*(i%4) -: 8];
    for (int rnd = 1; rnd <= 10; rnd++) begin
      for (int i = 0; i < 16; i++) s[i] = ref_sbox(s[i]);
      for (int c = 0; c < 4; c++)
        for (int r = 0; r < 4; r++) t[4*c+r] = s[4*((c+r)%4)+r];
      for (int c = 0; c < 4; c++)
        for (int r = 0; r < 4; r++)
          if (rnd < 10)
            s[4*c+r] = gmul(t[4*c+r], 8'h02) ^ gmul(t[4*c+(r+1)%4], 8'h03)
                     ^ t[4*c+(r+2)%4] ^ t[4*c+(r+3)%4];
          else
            s[4*c+r] = t[4*c+r];
      for (int i = 0; i < 16; i++) s[i] ^= w[4*rnd + i/4][31-8*(i%4) -: 8];
    end
    for (int i = 0; i < 16; i++) out[127-8*i -: 8] = s[i];
    return out;
  endfunction

  // Cycle-level expectation: accepted request finishes 10 clocks later.
  int           m_cnt  = 0;
  logic         m_done = 1'b0;
  logic [127:0] m_ct   = '0;
  logic [127:0] m_pend = '0;

  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      m_cnt  = 0;
      m_done = 1'b0;
      m_ct   = '0;
    end else begin
      m_done = 1'b0;
      if (m_cnt == 0) begin
        if (bus.start) begin
          m_cnt  = 10;
          m_pend = aes_ref(bus.plaintext, bus.key);
        end
      end else begin
        m_cnt--;
        if (m_cnt == 0) begin
          m_done = 1'b1;
          m_ct   = m_pend;
        end
      end
    end
  end

  always @(negedge clk) begin
    check("done_vs_model", 128'(bus.done), 128'(m_done));
    check("ct_vs_model", bus.ciphertext, m_ct);
`ifdef AES_BUSY_EN
    check("busy_vs_model", 128'(bus.busy), 128'(m_cnt != 0));
`endif
    if (bus.done) done_cnt++;
  end

  // ---------------- directed stimulus ----------------
  task automatic wait_done(output int lat);
    lat = 0;
    while (!bus.done && lat < 20) begin
      @(negedge clk);
      lat++;
    end
    if (!bus.done) lat = 99;
  endtask

  task automatic do_op(input string nm, input logic [127:0] p, input logic [127:0] k,
                       input logic [127:0] exp, input int repulse_at);
    int lat;
    int d0;
    d0 = done_cnt;
    @(negedge clk);
    bus.start = 1'b1; bus.plaintext = p; bus.key = k;
    @(negedge clk);
    bus.start = 1'b0; bus.plaintext = ~p; bus.key = ~k;
    lat = 0;
    while (!bus.done && lat < 20) begin
      @(negedge clk);
      lat++;
      bus.start = (lat == repulse_at);
    end
    if (!bus.done) lat = 99;
    bus.start = 1'b0;
    check({nm, "_latency"}, 128'(lat), 128'd10);
    check({nm, "_ct"}, bus.ciphertext, exp);
    repeat (3) @(negedge clk);
    #1;
    check({nm, "_done_count"}, 128'(done_cnt - d0), 128'd1);
    check({nm, "_ct_held"}, bus.ciphertext, exp);
  endtask

  initial begin
    int lat;
    int d0;
    bus.start = 1'b0; bus.plaintext = '0; bus.key = '0;

    check("model_c1", aes_ref(C1_PT, C1_KEY), C1_CT);
    check("model_zero", aes_ref('0, '0), Z_CT);
    check("model_ecb1", aes_ref(E_PT1, E_KEY), E_CT1);

    repeat (3) @(negedge clk);
    check("reset_done", 128'(bus.done), 128'd0);
    check("reset_ct", bus.ciphertext, 128'd0);
    #2 rst = 1'b1;
    repeat (2) @(negedge clk);

    do_op("c1", C1_PT, C1_KEY, C1_CT, -1);
    do_op("zero", '0, '0, Z_CT, -1);

    // Back-to-back blocks with start held high throughout.
    @(negedge clk);
    bus.start = 1'b1; bus.plaintext = E_PT1; bus.key = E_KEY;
    @(negedge clk);
    bus.plaintext = E_PT2;
    wait_done(lat);
    check("ecb1_latency", 128'(lat), 128'd10);
    check("ecb1_ct", bus.ciphertext, E_CT1);
    @(negedge clk);
    bus.start = 1'b0; bus.plaintext = '1;
    wait_done(lat);
    check("ecb2_latency", 128'(lat), 128'd10);
    check("ecb2_ct", bus.ciphertext, E_CT2);
    repeat (3) @(negedge clk);

    do_op("c1_repulse", C1_PT, C1_KEY, C1_CT, 5);

    // Abort at cycle 4 of an operation.
    @(negedge clk);
    bus.start = 1'b1; bus.plaintext = E_PT1; bus.key = E_KEY;
    @(negedge clk);
    bus.start = 1'b0;
    repeat (4) @(negedge clk);
    #2 rst = 1'b0;
    #1;
    check("abort_ct", bus.ciphertext, 128'd0);
    check("abort_done", 128'(bus.done), 128'd0);
    repeat (3) @(negedge clk);
    #2 rst = 1'b1;
    d0 = done_cnt;
    repeat (15) @(negedge clk);
    #1;
    check("abort_no_done", 128'(done_cnt - d0), 128'd0);
    check("abort_ct_zero", bus.ciphertext, 128'd0);

    do_op("c1_after_abort", C1_PT, C1_KEY, C1_CT, -1);

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
